// File: rtl/y86_execute_stage_if.sv
// Decode->Execute->Memory bundle of the Y86-64 execute stage.
// slave is the execute stage's view, master the driving environment's.
interface y86_execute_stage_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_stat;
  logic [3:0]      in_icode;
  logic [3:0]      in_ifun;
  logic [XLEN-1:0] in_valA;
  logic [XLEN-1:0] in_valB;
  logic [XLEN-1:0] in_valC;
  logic [3:0]      in_dstE;
  logic [3:0]      in_dstM;
  logic            m_exception;

  logic            out_valid;
  logic            out_ready;
  logic [2:0]      out_stat;
  logic [3:0]      out_icode;
  logic            out_Cnd;
  logic [XLEN-1:0] out_valE;
  logic [XLEN-1:0] out_valA;
  logic [3:0]      out_dstE;
  logic [3:0]      out_dstM;
  logic [2:0]      cc_out;
  logic            halted;

  modport slave (
    input  in_valid, in_stat, in_icode, in_ifun, in_valA, in_valB, in_valC,
           in_dstE, in_dstM, m_exception, out_ready,
    output in_ready, out_valid, out_stat, out_icode, out_Cnd, out_valE,
           out_valA, out_dstE, out_dstM, cc_out, halted
  );

  modport master (
    output in_valid, in_stat, in_icode, in_ifun, in_valA, in_valB, in_valC,
           in_dstE, in_dstM, m_exception, out_ready,
    input  in_ready, out_valid, out_stat, out_icode, out_Cnd, out_valE,
           out_valA, out_dstE, out_dstM, cc_out, halted
  );
endinterface

// File: rtl/y86_execute_stage.sv
// Y86-64 execute stage: operand select, ALU, condition codes, Cnd evaluation
// and the E->M pipeline register behind a valid/ready handshake.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_RUN   | normal operation, instructions accepted when the E->M slot frees
// S_HALTED| a non-AOK instruction was accepted; intake closed until rst
module y86_execute_stage #(
  parameter int         XLEN     = 64,
  parameter logic [2:0] STAT_AOK = 3'd1
) (
  input logic             clk,
  input logic             rst,
  y86_execute_stage_if.slave e
);

  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;
  localparam logic [3:0] R_NONE  = 4'hF;

  typedef enum logic {S_RUN, S_HALTED} state_t;
  typedef enum logic [1:0] {F_ADD, F_SUB, F_AND, F_XOR} alu_fn_t;

  state_t          state_q, state_d;
  logic [2:0]      cc_q;
  logic            accept;
  logic            cc_load;
  logic [XLEN-1:0] alu_a, alu_b, alu_res;
  logic            alu_of;
  alu_fn_t         alu_fn;
  logic            cnd;
  logic [3:0]      dst_e;
  logic            zf, sf, of;

  assign e.halted   = (state_q == S_HALTED);
  assign e.in_ready = !e.halted && (!e.out_valid || e.out_ready);
  assign e.cc_out   = cc_q;
  assign accept     = e.in_valid && e.in_ready;
  assign cc_load    = accept && (e.in_icode == I_OPQ) &&
                      (e.in_stat == STAT_AOK) && !e.m_exception;
  assign {zf, sf, of} = cc_q;

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (e.in_icode)
      I_CMOV, I_OPQ:             alu_a = e.in_valA;
      I_IRMOV, I_RMMOV, I_MRMOV: alu_a = e.in_valC;
      I_CALL, I_PUSH:            alu_a = ~XLEN'(7);
      I_RET, I_POP:              alu_a = XLEN'(8);
      default:                   alu_a = '0;
    endcase
    case (e.in_icode)
      I_RMMOV, I_MRMOV, I_OPQ, I_CALL, I_RET, I_PUSH, I_POP: alu_b = e.in_valB;
      default:                                               alu_b = '0;
    endcase
  end

  always_comb begin
    alu_fn = F_ADD;
    if (e.in_icode == I_OPQ) begin
      case (e.in_ifun)
        4'h1:    alu_fn = F_SUB;
        4'h2:    alu_fn = F_AND;
        4'h3:    alu_fn = F_XOR;
        default: alu_fn = F_ADD;
      endcase
    end
  end

  // sub is valB - aluA, so overflow compares the result sign against valB
  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    case (alu_fn)
      F_ADD: begin
        alu_res = alu_b + alu_a;
        alu_of  = (alu_a[XLEN-1] == alu_b[XLEN-1]) &&
                  (alu_res[XLEN-1] != alu_a[XLEN-1]);
      end
      F_SUB: begin
        alu_res = alu_b - alu_a;
        alu_of  = (alu_a[XLEN-1] != alu_b[XLEN-1]) &&
                  (alu_res[XLEN-1] != alu_b[XLEN-1]);
      end
      F_AND:   alu_res = alu_b & alu_a;
      default: alu_res = alu_b ^ alu_a;
    endcase
  end

  always_comb begin
    cnd = 1'b0;
    case (e.in_ifun)
      4'h0:    cnd = 1'b1;
      4'h1:    cnd = (sf ^ of) | zf;
      4'h2:    cnd = sf ^ of;
      4'h3:    cnd = zf;
      4'h4:    cnd = !zf;
      4'h5:    cnd = !(sf ^ of);
      4'h6:    cnd = !(sf ^ of) && !zf;
      default: cnd = 1'b0;
    endcase
  end

  assign dst_e = ((e.in_icode == I_CMOV) && !cnd) ? R_NONE : e.in_dstE;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:    if (accept && (e.in_stat != STAT_AOK)) state_d = S_HALTED;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst)          cc_q <= 3'b100;
    else if (cc_load) cc_q <= {(alu_res == '0), alu_res[XLEN-1], alu_of};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e.out_valid <= 1'b0;
      e.out_stat  <= STAT_AOK;
      e.out_icode <= I_NOP;
      e.out_Cnd   <= 1'b0;
      e.out_valE  <= '0;
      e.out_valA  <= '0;
      e.out_dstE  <= R_NONE;
      e.out_dstM  <= R_NONE;
    end else if (accept) begin
      e.out_valid <= 1'b1;
      e.out_stat  <= e.in_stat;
      e.out_icode <= e.in_icode;
      e.out_Cnd   <= cnd;
      e.out_valE  <= alu_res;
      e.out_valA  <= e.in_valA;
      e.out_dstE  <= dst_e;
      e.out_dstM  <= e.in_dstM;
    end else if (e.out_valid && e.out_ready) begin
      e.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_y86_execute_stage.sv
// Bench for y86_execute_stage: vector table through a scoreboard, plus
// backpressure, exception-drain and mid-stall reset sequences.
module tb_y86_execute_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  y86_execute_stage_if #(.XLEN(64)) ifc ();

  y86_execute_stage #(.XLEN(64), .STAT_AOK(3'd1)) dut (
    .clk (clk),
    .rst (rst),
    .e   (ifc.slave)
  );

  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic        mexc;
    logic [63:0] e_valE;
    logic        e_Cnd;
    logic [3:0]  e_dstE;
    logic [2:0]  e_cc;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic [2:0] stat, input logic [3:0] icode,
                              input logic [3:0] ifun, input logic [63:0] valA,
                              input logic [63:0] valB, input logic [63:0] valC,
                              input logic [3:0] dstE, input logic [3:0] dstM,
                              input logic mexc, input logic [63:0] e_valE,
                              input logic e_Cnd, input logic [3:0] e_dstE,
                              input logic [2:0] e_cc);
    vec_t v;
    v.stat = stat; v.icode = icode; v.ifun = ifun;
    v.valA = valA; v.valB = valB; v.valC = valC;
    v.dstE = dstE; v.dstM = dstM; v.mexc = mexc;
    v.e_valE = e_valE; v.e_Cnd = e_Cnd; v.e_dstE = e_dstE; v.e_cc = e_cc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_inputs(input vec_t v);
    ifc.in_valid    = 1'b1;
    ifc.in_stat     = v.stat;
    ifc.in_icode    = v.icode;
    ifc.in_ifun     = v.ifun;
    ifc.in_valA     = v.valA;
    ifc.in_valB     = v.valB;
    ifc.in_valC     = v.valC;
    ifc.in_dstE     = v.dstE;
    ifc.in_dstM     = v.dstM;
    ifc.m_exception = v.mexc;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input vec_t v, input bit push, output int waits);
    set_inputs(v);
    waits = 0;
    #1;
    while (!ifc.in_ready && waits < 20) begin
      @(negedge clk); #1;
      waits++;
    end
    if (!ifc.in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", waits);
    end else if (push) begin
      sb.push_back(v);
    end
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_out_valid"}, 64'(ifc.out_valid), 64'd0);
    chk({tag, "_halted"},    64'(ifc.halted),    64'd0);
    chk({tag, "_in_ready"},  64'(ifc.in_ready),  64'd1);
    chk({tag, "_cc"},        64'(ifc.cc_out),    64'h4);
    chk({tag, "_stat"},      64'(ifc.out_stat),  64'd1);
    chk({tag, "_icode"},     64'(ifc.out_icode), 64'd1);
    chk({tag, "_Cnd"},       64'(ifc.out_Cnd),   64'd0);
    chk({tag, "_valE"},      ifc.out_valE,       64'd0);
    chk({tag, "_valA"},      ifc.out_valA,       64'd0);
    chk({tag, "_dstE"},      64'(ifc.out_dstE),  64'hF);
    chk({tag, "_dstM"},      64'(ifc.out_dstM),  64'hF);
  endtask

  // Scoreboard consumer: compares each transfer out of the E->M register.
  initial begin
    int k = 0;
    forever begin
      @(negedge clk); #2;
      if (!rst && ifc.out_valid && ifc.out_ready) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sb_unexpected: output icode 0x%0h with empty scoreboard, required none", ifc.out_icode);
        end else begin
          vec_t v;
          string t;
          v = sb.pop_front();
          t = $sformatf("out%0d", k);
          chk({t, "_stat"},  64'(ifc.out_stat),  64'(v.stat));
          chk({t, "_icode"}, 64'(ifc.out_icode), 64'(v.icode));
          chk({t, "_Cnd"},   64'(ifc.out_Cnd),   64'(v.e_Cnd));
          chk({t, "_valE"},  ifc.out_valE,       v.e_valE);
          chk({t, "_valA"},  ifc.out_valA,       v.valA);
          chk({t, "_dstE"},  64'(ifc.out_dstE),  64'(v.e_dstE));
          chk({t, "_dstM"},  64'(ifc.out_dstM),  64'(v.dstM));
          chk({t, "_cc"},    64'(ifc.cc_out),    64'(v.e_cc));
          k++;
        end
      end
    end
  end

  initial begin
    int   w, wsum;
    vec_t p, q, r, x;
    logic [2:0] last_cc;

    ifc.in_valid = 1'b0; ifc.in_stat = 3'd1; ifc.in_icode = 4'h1; ifc.in_ifun = 4'h0;
    ifc.in_valA = '0; ifc.in_valB = '0; ifc.in_valC = '0;
    ifc.in_dstE = 4'hF; ifc.in_dstM = 4'hF; ifc.m_exception = 1'b0;
    ifc.out_ready = 1'b1;

    //          stat icode ifun valA                  valB                  valC     dE    dM    mx  e_valE                Cnd  e_dE  cc
    tbl.push_back(mk(1, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1,             64'h0,   4'h2, 4'hF, 0, 64'h8000_0000_0000_0000, 1, 4'h2, 3'b011));
    tbl.push_back(mk(1, 4'h6, 4'h1, 64'h5,               64'h5,                 64'h0,   4'h4, 4'hF, 0, 64'h0,               0, 4'h4, 3'b100));
    tbl.push_back(mk(1, 4'h2, 4'h1, 64'h1234,            64'h0,                 64'h0,   4'h3, 4'hF, 0, 64'h1234,            1, 4'h3, 3'b100));
    tbl.push_back(mk(1, 4'h2, 4'h6, 64'h55,              64'h0,                 64'h0,   4'h3, 4'hF, 0, 64'h55,              0, 4'hF, 3'b100));
    tbl.push_back(mk(1, 4'hA, 4'h0, 64'hAA,              64'h100,               64'h0,   4'h4, 4'hF, 0, 64'hF8,              1, 4'h4, 3'b100));
    tbl.push_back(mk(1, 4'hB, 4'h0, 64'hF8,              64'hF8,                64'h0,   4'h4, 4'h0, 0, 64'h100,             1, 4'h4, 3'b100));
    tbl.push_back(mk(1, 4'h3, 4'h0, 64'h0,               64'h0,                 64'h42,  4'h5, 4'hF, 0, 64'h42,              1, 4'h5, 3'b100));
    tbl.push_back(mk(1, 4'h5, 4'h0, 64'h0,               64'h20,                64'h10,  4'hF, 4'h6, 0, 64'h30,              1, 4'hF, 3'b100));
    tbl.push_back(mk(1, 4'h6, 4'h2, 64'hF0,              64'h3C,                64'h0,   4'h7, 4'hF, 0, 64'h30,              0, 4'h7, 3'b000));
    tbl.push_back(mk(1, 4'h6, 4'h3, 64'hFF,              64'hFF,                64'h0,   4'h8, 4'hF, 1, 64'h0,               0, 4'h8, 3'b000));
    tbl.push_back(mk(1, 4'h6, 4'h1, 64'h1,               64'h8000_0000_0000_0000, 64'h0, 4'h9, 4'hF, 0, 64'h7FFF_FFFF_FFFF_FFFF, 0, 4'h9, 3'b001));
    tbl.push_back(mk(1, 4'h7, 4'h2, 64'h0,               64'h0,                 64'h0,   4'hF, 4'hF, 0, 64'h0,               1, 4'hF, 3'b001));
    tbl.push_back(mk(1, 4'h2, 4'h5, 64'h7,               64'h0,                 64'h0,   4'h3, 4'hF, 0, 64'h7,               0, 4'hF, 3'b001));
    tbl.push_back(mk(1, 4'h7, 4'h7, 64'h0,               64'h0,                 64'h0,   4'hF, 4'hF, 0, 64'h0,               0, 4'hF, 3'b001));
    tbl.push_back(mk(1, 4'h6, 4'h5, 64'h3,               64'h4,                 64'h0,   4'hA, 4'hF, 0, 64'h7,               0, 4'hA, 3'b000));
    tbl.push_back(mk(1, 4'h8, 4'h0, 64'h0,               64'h200,               64'h400, 4'h4, 4'hF, 0, 64'h1F8,             1, 4'h4, 3'b000));
    tbl.push_back(mk(1, 4'h6, 4'h1, 64'h2,               64'h1,                 64'h0,   4'hB, 4'hF, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 4'hB, 3'b010));
    tbl.push_back(mk(1, 4'h2, 4'h1, 64'h9,               64'h0,                 64'h0,   4'h3, 4'hF, 0, 64'h9,               1, 4'h3, 3'b010));
    tbl.push_back(mk(1, 4'h6, 4'h0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 4'hC, 4'hF, 0, 64'h0,     1, 4'hC, 3'b101));
    tbl.push_back(mk(1, 4'h2, 4'h4, 64'hABC,             64'h0,                 64'h0,   4'h3, 4'hF, 0, 64'hABC,             0, 4'hF, 3'b101));
    last_cc = 3'b101;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset("reset0");

    // Streamed vectors with the memory stage always ready.
    wsum = 0;
    foreach (tbl[i]) begin
      send(tbl[i], 1'b1, w);
      wsum += w;
    end
    ifc.in_valid = 1'b0;
    chk("stream_no_bubble_waits", 64'(wsum), 64'd0);
    repeat (3) @(negedge clk);
    chk("stream_sb_drained", 64'(sb.size()), 64'd0);

    // Backpressure: hold P in the register while Q waits.
    p = mk(1, 4'h3, 4'h0, 64'h0,   64'h0,   64'h111, 4'h1, 4'hF, 0, 64'h111, 1, 4'h1, last_cc);
    q = mk(1, 4'h2, 4'h0, 64'h222, 64'h0,   64'h0,   4'h2, 4'hF, 0, 64'h222, 1, 4'h2, last_cc);
    r = mk(1, 4'hB, 4'h0, 64'h0,   64'h300, 64'h0,   4'h4, 4'hF, 0, 64'h308, 1, 4'h4, last_cc);
    ifc.out_ready = 1'b0;
    send(p, 1'b1, w);
    set_inputs(q);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d_in_ready", c),  64'(ifc.in_ready),  64'd0);
      chk($sformatf("stall%0d_out_valid", c), 64'(ifc.out_valid), 64'd1);
      chk($sformatf("stall%0d_valE", c),      ifc.out_valE,       64'h111);
      chk($sformatf("stall%0d_dstE", c),      64'(ifc.out_dstE),  64'h1);
      chk($sformatf("stall%0d_icode", c),     64'(ifc.out_icode), 64'h3);
      @(negedge clk);
    end
    ifc.out_ready = 1'b1;
    send(q, 1'b1, w);
    chk("release_q_waits", 64'(w), 64'd0);
    send(r, 1'b1, w);
    chk("release_r_waits", 64'(w), 64'd0);
    ifc.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("release_sb_drained", 64'(sb.size()), 64'd0);

    // Exception: forwarded and drained, then intake stays closed.
    x = mk(3'd4, 4'h6, 4'h0, 64'h1, 64'h1, 64'h0, 4'h7, 4'hF, 0, 64'h2, 1, 4'h7, last_cc);
    send(x, 1'b1, w);
    #1;
    chk("exc_halted", 64'(ifc.halted), 64'd1);
    chk("exc_in_ready", 64'(ifc.in_ready), 64'd0);
    set_inputs(p);
    repeat (3) @(negedge clk);
    #1;
    chk("exc_after_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("exc_after_halted", 64'(ifc.halted), 64'd1);
    chk("exc_after_in_ready", 64'(ifc.in_ready), 64'd0);
    chk("exc_after_cc", 64'(ifc.cc_out), 64'(last_cc));
    chk("exc_sb_drained", 64'(sb.size()), 64'd0);

    // Reset out of HALTED.
    @(negedge clk);
    ifc.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset("reset_halted");

    // Reset in the middle of a stall.
    @(negedge clk);
    ifc.out_ready = 1'b0;
    send(p, 1'b0, w);
    set_inputs(q);
    #1;
    chk("midstall_in_ready", 64'(ifc.in_ready), 64'd0);
    chk("midstall_out_valid", 64'(ifc.out_valid), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ifc.in_valid = 1'b0;
    #1;
    check_reset("reset_stall");

    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
